// File: rtl/fifo_monitor.sv
// fifo_monitor: shadow reference model of a single-clock FIFO that checks the
// DUT's flags and read data pin-by-pin and reports errors as sticky flags,
// one-cycle pulses and saturating counters.
module fifo_monitor #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int ERR_CNT_W  = 8,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_write,
  input  logic                  fifo_read,
  input  logic [FIFO_WIDTH-1:0] fifo_data_in,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic                  clear,
  output logic [4:0]            err_flags,
  output logic [4:0]            err_pulse,
  output logic [ERR_CNT_W-1:0]  wof_cnt,
  output logic [ERR_CNT_W-1:0]  roe_cnt,
  output logic [ERR_CNT_W-1:0]  data_err_cnt,
  output logic [CW-1:0]         model_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [FIFO_WIDTH-1:0] exp_data_p0;
  logic [FIFO_WIDTH-1:0] exp_data_p1;
  logic                  vld_p1;
  logic [4:0]            ev;

  // Saturating event counter; a same-cycle event beats clear and reads as 1.
  function automatic logic [ERR_CNT_W-1:0] sat_cnt(input logic [ERR_CNT_W-1:0] cur,
                                                   input logic hit,
                                                   input logic clr);
    logic [ERR_CNT_W-1:0] nxt;
    if (hit) begin
      if (clr)       nxt = ERR_CNT_W'(1);
      else if (&cur) nxt = cur;
      else           nxt = cur + 1'b1;
    end else begin
      nxt = clr ? '0 : cur;
    end
    return nxt;
  endfunction

  // Pointer advance with wrap at the last entry (depth need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Acceptance from the model occupancy only, and the per-cycle event checks.
  always_comb begin
    wr_acc      = fifo_write && (model_count < DEPTH_C);
    rd_acc      = fifo_read && (model_count != '0);
    exp_data_p0 = mem[rd_ptr];
    ev          = '0;
    ev[0]       = fifo_empty != (model_count == '0);
    ev[1]       = fifo_full != (model_count == DEPTH_C);
    ev[2]       = fifo_write && (model_count == DEPTH_C);
    ev[3]       = fifo_read && (model_count == '0);
    if (RD_LATENCY == 0) ev[4] = rd_acc && (fifo_data_out != exp_data_p0);
    else                 ev[4] = vld_p1 && (fifo_data_out != exp_data_p1);
  end

  // Model storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= fifo_data_in;
  end

  // Model pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      model_count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   model_count <= model_count + 1'b1;
        2'b01:   model_count <= model_count - 1'b1;
        default: model_count <= model_count;
      endcase
    end
  end

  // ---- p0 -> p1: expected word held for the delayed-data compare ----
  // Expected read word; data path carries no reset.
  always_ff @(posedge clk) begin
    exp_data_p1 <= exp_data_p0;
  end

  // Pending-compare valid; reset drops any compare still in flight.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= rd_acc;
  end

  // Registered error reporting: pulses, sticky flags and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse    <= '0;
      err_flags    <= '0;
      wof_cnt      <= '0;
      roe_cnt      <= '0;
      data_err_cnt <= '0;
    end else begin
      err_pulse    <= ev;
      err_flags    <= clear ? ev : (err_flags | ev);
      wof_cnt      <= sat_cnt(wof_cnt, ev[2], clear);
      roe_cnt      <= sat_cnt(roe_cnt, ev[3], clear);
      data_err_cnt <= sat_cnt(data_err_cnt, ev[4], clear);
    end
  end

endmodule

// File: tb/tb_fifo_monitor.sv
// Directed bench for fifo_monitor: the bench plays the FIFO pins by hand and
// checks the monitor outputs against hand-computed values.
module tb_fifo_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_write, fifo_read, fifo_full, fifo_empty, clear;
  logic [7:0] fifo_data_in, fifo_data_out;
  logic [4:0] err_flags, err_pulse, s_flags, s_pulse;
  logic [7:0] wof_cnt, roe_cnt, data_err_cnt;
  logic [1:0] s_wof, s_roe, s_derr;
  logic [3:0] model_count, s_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_monitor #(.FIFO_DEPTH(8), .FIFO_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_data_in(fifo_data_in), .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .clear(clear),
    .err_flags(err_flags), .err_pulse(err_pulse), .wof_cnt(wof_cnt),
    .roe_cnt(roe_cnt), .data_err_cnt(data_err_cnt), .model_count(model_count)
  );

  // Narrow-counter instance on the same pins, used for saturation checks.
  fifo_monitor #(.FIFO_DEPTH(8), .FIFO_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_data_in(fifo_data_in), .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .clear(clear),
    .err_flags(s_flags), .err_pulse(s_pulse), .wof_cnt(s_wof),
    .roe_cnt(s_roe), .data_err_cnt(s_derr), .model_count(s_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] rd_vals [8];
    for (int i = 0; i < 8; i++) rd_vals[i] = 8'(i + 1);
    rd_vals[4] = 8'h55;

    rst = 1'b1; fifo_write = 0; fifo_read = 0; fifo_full = 0; fifo_empty = 1;
    clear = 0; fifo_data_in = '0; fifo_data_out = '0;
    step(); step();
    chk("rst_flags", err_flags, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_count", model_count, 0);
    chk("rst_cnts", {wof_cnt, roe_cnt, data_err_cnt}, 0);
    rst = 1'b0;
    step();
    chk("idle_pulse", err_pulse, 0);

    // Clean fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      fifo_write = 1; fifo_data_in = 8'(i); fifo_empty = (i == 1); fifo_full = 0;
      step();
      chk($sformatf("fill_count%0d", i), model_count, i);
      chk($sformatf("fill_pulse%0d", i), err_pulse, 0);
    end
    fifo_write = 0; fifo_empty = 0; fifo_full = 1;
    step();
    chk("full_ok_pulse", err_pulse, 0);

    // Three writes on full
    for (int i = 0; i < 3; i++) begin
      fifo_write = 1;
      step();
      chk("wof_pulse", err_pulse, 5'b00100);
      chk("wof_count", model_count, 8);
    end
    fifo_write = 0;
    chk("wof_cnt", wof_cnt, 3);
    step();
    chk("wof_pulse_off", err_pulse, 0);
    chk("wof_sticky", err_flags, 5'b00100);

    // Drain with corrupted 5th word; data appears the cycle after each read
    for (int i = 1; i <= 8; i++) begin
      fifo_read = 1; fifo_empty = 0; fifo_full = (i == 1);
      fifo_data_out = (i > 1) ? rd_vals[i-2] : 8'h00;
      step();
      chk($sformatf("drain_pulse%0d", i), err_pulse, (i == 6) ? 5'b10000 : 5'b00000);
    end
    fifo_read = 0; fifo_empty = 1; fifo_full = 0; fifo_data_out = rd_vals[7];
    step();
    chk("drain_last_pulse", err_pulse, 0);
    chk("drain_count", model_count, 0);
    chk("data_err_cnt", data_err_cnt, 1);

    // Empty: simultaneous read and write of 0xA5
    fifo_read = 1; fifo_write = 1; fifo_data_in = 8'hA5; fifo_empty = 1;
    step();
    chk("roe_pulse", err_pulse, 5'b01000);
    chk("roe_cnt1", roe_cnt, 1);
    chk("rw_empty_count", model_count, 1);
    fifo_write = 0; fifo_read = 1; fifo_empty = 0;
    step();
    fifo_read = 0; fifo_empty = 1; fifo_data_out = 8'hA5;
    step();
    chk("a5_pulse", err_pulse, 0);
    chk("a5_derr", data_err_cnt, 1);
    fifo_data_out = 8'h5A;
    chk("a5_count", model_count, 0);

    // Empty flag stuck high with two entries
    fifo_write = 1; fifo_data_in = 8'h11; fifo_empty = 1;
    step();
    fifo_data_in = 8'h22; fifo_empty = 0;
    step();
    chk("two_count", model_count, 2);
    fifo_write = 0; fifo_empty = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("empty_mm_pulse", err_pulse, 5'b00001);
    end
    clear = 1; fifo_empty = 0;
    step();
    chk("clr_flags", err_flags, 0);
    chk("clr_cnts", {wof_cnt, roe_cnt, data_err_cnt}, 0);
    chk("clr_count", model_count, 2);
    fifo_empty = 1;
    step();
    chk("clr_evt_flags", err_flags, 5'b00001);
    clear = 0; fifo_empty = 0;

    // Drain two, then five reads on empty
    fifo_read = 1; fifo_empty = 0;
    step();
    fifo_data_out = 8'h11;
    step();
    chk("d11_pulse", err_pulse, 0);
    fifo_empty = 1; fifo_data_out = 8'h22;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("roe5_pulse", err_pulse, 5'b01000);
    end
    fifo_read = 0;
    chk("roe5_cnt", roe_cnt, 5);
    chk("roe_sat", s_roe, 3);

    // Reset mid-drain with a pending compare
    fifo_write = 1; fifo_data_in = 8'h31; fifo_empty = 1;
    step();
    fifo_data_in = 8'h32; fifo_empty = 0;
    step();
    fifo_write = 0; fifo_read = 1;
    step();
    rst = 1; fifo_read = 0; fifo_data_out = 8'hFF; fifo_empty = 1;
    step();
    chk("mrst_pulse", err_pulse, 0);
    chk("mrst_flags", err_flags, 0);
    chk("mrst_cnts", {wof_cnt, roe_cnt, data_err_cnt}, 0);
    chk("mrst_count", model_count, 0);
    chk("mrst_sat_cnt", s_roe, 0);
    rst = 0;
    step();
    chk("post_rst_pulse", err_pulse, 0);
    fifo_empty = 0;
    step();
    chk("post_rst_empty_mm", err_pulse, 5'b00001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_monitor.md
# fifo_monitor

Synthesizable protocol and data monitor for a single-clock FIFO DUT. It keeps its own reference model of the FIFO contents and occupancy, and flags five conditions:

- empty-flag mismatch
- full-flag mismatch
- write to a full FIFO
- read from an empty FIFO
- read-data mismatch

It reports them through sticky flags, single-cycle pulses and saturating counters. It sits beside the FIFO in the testbench or on silicon debug, connected only to the FIFO's pins. It works at any depth and width and with either read latency.

## Interface
- FIFO_DEPTH, 8, entries in the monitored FIFO; any integer ≥ 2 (not required to be a power of two)
- FIFO_WIDTH, 8, data width in bits
- RD_LATENCY, 1, cycles from an accepted fifo_read to valid fifo_data_out; legal values 0 or 1
- ERR_CNT_W, 8, width of each error counter
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- fifo_write  input  1  DUT write request
- fifo_read  input  1  DUT read request
- fifo_data_in  input  FIFO_WIDTH  DUT write data
- fifo_data_out  input  FIFO_WIDTH  DUT read data
- fifo_full  input  1  DUT full flag
- fifo_empty  input  1  DUT empty flag
- clear  input  1  synchronous clear of err_flags and all counters; the model is untouched
- err_flags  output  5  sticky: [0] empty mismatch, [1] full mismatch, [2] write on full, [3] read on empty, [4] data mismatch
- err_pulse  output  5  same bit map, high for exactly one cycle per detected event
- wof_cnt  output  ERR_CNT_W  count of write-on-full events
- roe_cnt  output  ERR_CNT_W  count of read-on-empty events
- data_err_cnt  output  ERR_CNT_W  count of data mismatches
- model_count  output  $clog2(FIFO_DEPTH+1)  reference occupancy

## Operation
- The model has storage FIFO_DEPTH × FIFO_WIDTH, a write pointer, a read pointer and a count.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
- Acceptance is decided from model_count at the start of the cycle, never from the DUT flags:
  - write accepted iff fifo_write && model_count < FIFO_DEPTH
  - read accepted iff fifo_read && model_count > 0
- When full and both requests are asserted, the read is accepted and the write is rejected. The count becomes FIFO_DEPTH-1.
- When empty and both requests are asserted, the write is accepted and the read is rejected. The count becomes 1.
- Count update: +1 for an accepted write alone, -1 for an accepted read alone, unchanged when both are accepted.
- An accepted write stores fifo_data_in at the write pointer and advances the pointer.
- An accepted read advances the read pointer. The expected data is the model entry at the read pointer before it advances.
- Checks are evaluated every cycle that rst is low:
  - bit0: fifo_empty != (model_count == 0)
  - bit1: fifo_full != (model_count == FIFO_DEPTH)
  - bit2: fifo_write && model_count == FIFO_DEPTH (a warning class, but it is counted)
  - bit3: fifo_read && model_count == 0
  - bit4: fifo_data_out != expected data, at the compare point of an accepted read
- Compare point:
  - RD_LATENCY=0: the same cycle as the accepted read.
  - RD_LATENCY=1: the following cycle, using the expected word and valid bit held in a one-stage pipeline register.
- Counters saturate at all-ones and never wrap.
- clear and a new event in the same cycle: the event wins, so the flag reads 1 and the counter reads 1.
- Reset values:
  - err_flags, err_pulse, all counters, model_count and both pointers: 0
  - pending-compare valid: 0

## Timing
- All outputs are registered.
- An event sampled at edge N appears on err_pulse, err_flags and the counters after edge N, and is visible during cycle N+1.
- model_count reflects the accepted operations of edge N after edge N.
- Data-mismatch latency, from the read-request edge to the visible flag:
  - RD_LATENCY=1: the read is accepted at edge N, data is sampled at edge N+1, and the flag is visible after edge N+1.
  - RD_LATENCY=0: the flag is visible after edge N.
- Back-to-back accepted reads each get an independent compare. No stall is ever applied to the DUT.
- Reset asserted mid-operation: at the next edge the model empties and any pending RD_LATENCY=1 compare is dropped. No check fires in a cycle where rst=1.
- First cycle after reset release: the checks are live. A DUT that still shows fifo_empty=0 there raises bit0.

## Test plan
- Reset, then a clean fill of 8 writes (data 0x01..0x08) with a correct DUT:
  - model_count steps 1..8.
  - No err_pulse bits fire.
  - fifo_full=1 in the cycle after the 8th write yields bit1=0.
- With the FIFO full, assert fifo_write for 3 cycles with read low:
  - err_pulse[2] fires 3 times and wof_cnt=3.
  - model_count stays 8.
  - err_flags[2] stays set after the writes stop.
- Drain with 8 reads, RD_LATENCY=1, where the DUT returns 0x01..0x08 but 0x05 is corrupted to 0x55:
  - Exactly one err_pulse[4] fires, one cycle after the 5th read.
  - data_err_cnt=1.
- Empty FIFO, simultaneous read and write of 0xA5:
  - err_pulse[3]=1 and roe_cnt=1.
  - model_count=1.
  - The next read expects 0xA5.
- A DUT that holds fifo_empty=1 while model_count=2:
  - err_pulse[0] fires every such cycle.
  - Asserting clear for one cycle with no event zeroes err_flags and all counters; model_count is unchanged.
- Set ERR_CNT_W=2 and perform 5 reads on empty:
  - roe_cnt saturates at 3.
  - Asserting rst mid-drain with a pending compare yields no bit4 event, and all outputs are 0 after the edge.
